// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported 4B memory between the imem and dmem request streams,
//           round-robin on conflict, routing in-order responses back via a grant-order tag FIFO.
// Latency : zero cycles; request and response paths are purely combinational, no data registers.
// Backpr. : a requester stalls while it loses, while memory is not ready, or while
//           p_max_inflight requests are outstanding; responses stall on the routed requester's rdy.
//
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   imem_req_* / dmem_req_*  requester val/rdy request channels (mem_req_4B_t)
//   mem_req_*                merged request channel towards memory
//   mem_resp_*               in-order response channel from memory (mem_resp_4B_t)
//   imem_resp_* / dmem_resp_* routed response channels, payload passed through unmodified
//   num_inflight             number of granted requests still awaiting a response

package mem_port_arbiter_pkg;

   // Request message for a 4-byte memory port.
   typedef struct packed {
      logic [2:0]  typ;     // read / write / etc., opaque to the arbiter
      logic [7:0]  opaque;  // requester-owned tag, returned in the response
      logic [31:0] addr;
      logic [1:0]  len;     // 0 encodes a full 4-byte access
      logic [31:0] data;
   } mem_req_4B_t;

   // Response message for a 4-byte memory port.
   typedef struct packed {
      logic [2:0]  typ;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

endpackage

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int p_max_inflight = 4
) (
   input  logic                              clk,
   input  logic                              reset,

   input  mem_req_4B_t                       imem_req_msg,
   input  logic                              imem_req_val,
   output logic                              imem_req_rdy,

   input  mem_req_4B_t                       dmem_req_msg,
   input  logic                              dmem_req_val,
   output logic                              dmem_req_rdy,

   output mem_req_4B_t                       mem_req_msg,
   output logic                              mem_req_val,
   input  logic                              mem_req_rdy,

   input  mem_resp_4B_t                      mem_resp_msg,
   input  logic                              mem_resp_val,
   output logic                              mem_resp_rdy,

   output mem_resp_4B_t                      imem_resp_msg,
   output logic                              imem_resp_val,
   input  logic                              imem_resp_rdy,

   output mem_resp_4B_t                      dmem_resp_msg,
   output logic                              dmem_resp_val,
   input  logic                              dmem_resp_rdy,

   output logic [$clog2(p_max_inflight):0]   num_inflight
);

   localparam int c_ptr_w = $clog2(p_max_inflight);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(p_max_inflight);

   // Tag encoding: 0 = imem, 1 = dmem. The same encoding is used for prio.
   localparam logic c_tag_imem = 1'b0;
   localparam logic c_tag_dmem = 1'b1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                         prio_q, prio_d;   // requester favoured on a tie
   logic [p_max_inflight-1:0]    tags_q, tags_d;   // grant-order tag storage
   logic [c_ptr_w-1:0]           head_q, head_d;   // oldest outstanding tag
   logic [c_ptr_w-1:0]           tail_q, tail_d;   // next free slot
   logic [c_cnt_w-1:0]           occ_q,  occ_d;    // outstanding request count

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic fifo_full;
   logic fifo_empty;
   logic any_req_val;
   logic win_tag;
   logic can_issue;
   logic req_fire;
   logic head_tag;
   logic route_en;
   logic resp_fire;

   // ------------------------------------------------------------------
   // Request side: pick a winner and forward it unmodified
   // ------------------------------------------------------------------
   always_comb begin
      fifo_full   = (occ_q == c_full_cnt);
      any_req_val = imem_req_val | dmem_req_val;

      // A lone requester always wins; a tie is broken by prio. With no
      // requester valid the choice is irrelevant, prio is reused for it.
      if (imem_req_val && !dmem_req_val) begin
         win_tag = c_tag_imem;
      end else if (dmem_req_val && !imem_req_val) begin
         win_tag = c_tag_dmem;
      end else begin
         win_tag = prio_q;
      end

      // The full check uses the registered count only, so a dequeue in the
      // same cycle never frees a slot early; this also keeps mem_resp_* out
      // of the request path.
      can_issue   = reset && !fifo_full && mem_req_rdy;
      mem_req_val = reset && !fifo_full && any_req_val;
      mem_req_msg = (win_tag == c_tag_dmem) ? dmem_req_msg : imem_req_msg;

      imem_req_rdy = can_issue && (win_tag == c_tag_imem);
      dmem_req_rdy = can_issue && (win_tag == c_tag_dmem);

      req_fire = mem_req_val && mem_req_rdy;
   end

   // ------------------------------------------------------------------
   // Response side: head tag steers the in-order response stream
   // ------------------------------------------------------------------
   always_comb begin
      fifo_empty = (occ_q == '0);
      head_tag   = tags_q[head_q];

      // With nothing outstanding a response has no owner, so it is held off.
      route_en = reset && !fifo_empty;

      imem_resp_msg = mem_resp_msg;
      dmem_resp_msg = mem_resp_msg;

      imem_resp_val = route_en && (head_tag == c_tag_imem) && mem_resp_val;
      dmem_resp_val = route_en && (head_tag == c_tag_dmem) && mem_resp_val;

      mem_resp_rdy  = route_en &&
                      ((head_tag == c_tag_dmem) ? dmem_resp_rdy : imem_resp_rdy);

      resp_fire     = mem_resp_val && mem_resp_rdy;

      num_inflight  = reset ? occ_q : '0;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      prio_d = prio_q;
      tags_d = tags_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;

      if (req_fire) begin
         tags_d[tail_q] = win_tag;
         tail_d         = tail_q + c_ptr_w'(1);   // wraps: depth is a power of two
         prio_d         = !win_tag;               // the winner goes to the back
      end

      if (resp_fire) begin
         head_d = head_q + c_ptr_w'(1);
      end

      // Simultaneous enqueue and dequeue leave the count unchanged.
      case ({req_fire, resp_fire})
         2'b10:   occ_d = occ_q + c_cnt_w'(1);
         2'b01:   occ_d = occ_q - c_cnt_w'(1);
         default: occ_d = occ_q;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_q <= c_tag_imem;
         tags_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         prio_q <= prio_d;
         tags_q <= tags_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported 4B memory between the processor's instruction-fetch stream and its data stream. It merges the imem and dmem request streams onto one memory request port with round-robin priority. It records the grant order in an in-flight tag FIFO and uses that FIFO to route in-order memory responses back to the correct requester. It sits between the processor's imem/dmem val/rdy ports and a single test memory port.

## Interface
Parameters:
- p_max_inflight, 4: depth of the grant-order FIFO, i.e. the maximum number of outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low (asserted when 0), sampled on the rising edge of clk.
- imem_req_msg  in  mem_req_4B_t  instruction request.
- imem_req_val  in  1  instruction request valid.
- imem_req_rdy  out  1  instruction request accepted.
- dmem_req_msg  in  mem_req_4B_t  data request.
- dmem_req_val  in  1  data request valid.
- dmem_req_rdy  out  1  data request accepted.
- mem_req_msg  out  mem_req_4B_t  request forwarded to memory.
- mem_req_val  out  1  forwarded request valid.
- mem_req_rdy  in  1  memory accepts the request.
- mem_resp_msg  in  mem_resp_4B_t  response from memory.
- mem_resp_val  in  1  memory response valid.
- mem_resp_rdy  out  1  arbiter accepts the response.
- imem_resp_msg / dmem_resp_msg  out  mem_resp_4B_t  routed response; both carry mem_resp_msg unmodified.
- imem_resp_val / dmem_resp_val  out  1  routed response valid.
- imem_resp_rdy / dmem_resp_rdy  in  1  requester accepts the response.
- num_inflight  out  $clog2(p_max_inflight)+1  number of outstanding requests.

## Operation
- State:
  - Priority bit `prio` (0 = imem first, 1 = dmem first).
  - Grant-order FIFO of 1-bit tags (0 = imem, 1 = dmem) with head/tail pointers.
  - Occupancy counter.
- Grant (combinational):
  - can_issue = !full && mem_req_rdy && reset deasserted.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester selected by `prio` wins.
  - mem_req_val = imem_req_val | dmem_req_val, gated by !full and by reset.
  - mem_req_msg = the winner's msg, passed through unmodified, opaque included.
  - Winner's req_rdy = can_issue; loser's req_rdy = 0.
- On a request handshake (mem_req_val && mem_req_rdy):
  - Enqueue the winner's tag.
  - Set prio to the opposite of the winner.
  - Leave prio unchanged on any cycle with no handshake.
- Response routing:
  - If the FIFO is empty, mem_resp_rdy = 0 and both resp_val = 0; the response is not consumed.
  - Otherwise the head tag selects the destination: X_resp_val = mem_resp_val, mem_resp_rdy = X_resp_rdy; the other requester's resp_val = 0.
  - A response handshake dequeues the head tag.
- Memory must return responses in request order; the arbiter does not reorder.
- Occupancy:
  - Incremented on enqueue only, decremented on dequeue only, unchanged when both happen in the same cycle.
  - num_inflight = occupancy.
  - Pointers wrap modulo p_max_inflight.
- Full FIFO:
  - No grant while occupancy == p_max_inflight, even if a dequeue occurs in the same cycle.
  - Grant resumes the following cycle.
- Empty FIFO: an enqueue and a dequeue cannot occur in the same cycle, because responses are blocked when the FIFO is empty.

## Timing
- Request path: zero latency, combinational val→val, msg→msg and rdy→rdy; no registers in the request path.
- Response path: zero latency, combinational from head tag and inputs.
- No combinational path from mem_resp_* to mem_req_*.
- Reset (reset == 0 on a rising edge):
  - Occupancy = 0, head = tail = 0, prio = 0.
  - While reset is low, all outputs are 0: every val and rdy output, and num_inflight.
  - Reset asserted mid-operation discards all in-flight tags. Responses that arrive later find the FIFO empty and are blocked; the system resets memory together with the arbiter.
- Throughput: one grant and one response per cycle. A sustained single requester with a 1-cycle memory reaches full bandwidth while occupancy stays below p_max_inflight.

## Test plan
- Reset: hold reset=0 for 2 cycles with both val=1 → all val/rdy outputs 0 and num_inflight=0. Release reset → imem granted first (prio=0).
- Alternation: both requesters valid every cycle, mem_req_rdy=1, memory returns responses 1 cycle later in order → grants alternate I,D,I,D. Each response (data = addr) reaches the matching port, e.g. imem addr 0x200 returns 0x200 on imem_resp_msg.data.
- Single requester: dmem only, 6 back-to-back requests, immediate responses → 6 dmem grants, no imem_resp_val, num_inflight never exceeds 2.
- Full: mem_resp_val=0 and 5 imem requests with p_max_inflight=4 → 4 accepted, 5th sees imem_req_rdy=0 and num_inflight=4. One response completes → the 5th is granted on the next cycle, not the same cycle.
- Backpressure: head tag dmem, dmem_resp_rdy=0 for 3 cycles while imem_resp_rdy=1 → mem_resp_rdy=0 and the FIFO is unchanged. dmem_resp_rdy=1 → dequeue, and the next response routes to imem.
- Mid-operation reset: 3 requests in flight, reset=0 for 1 cycle → num_inflight=0. A stray mem_resp_val=1 afterwards sees mem_resp_rdy=0.
